// File: rtl/instr_fetch2_wide.sv
// Second fetch stage: ITLB/I-cache way resolution, aligned fetch-block register,
// fault classification, and a refill/replay state machine for misses.
module instr_fetch2_wide #(
    parameter int ITLB_WAYS   = 4,
    parameter int ICACHE_WAYS = 4,
    parameter int VA_W        = 32,
    parameter int PA_W        = 34,
    parameter int ASID_W      = 9,
    parameter int PAGE_BITS   = 12,
    parameter int LINE_BYTES  = 64,
    parameter int ICACHE_SETS = 64,
    parameter int FETCH_BYTES = 8,
    localparam int VPN_W      = VA_W - PAGE_BITS,
    localparam int PPN_W      = PA_W - PAGE_BITS,
    localparam int PTAG_W     = PA_W - $clog2(LINE_BYTES * ICACHE_SETS),
    localparam int LINE_W     = LINE_BYTES * 8,
    localparam int FETCH_W    = FETCH_BYTES * 8
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic                          i_stall,
    input  logic                          i_flush,
    input  logic                          i_valid,
    input  logic [VA_W-1:0]               i_pc,
    input  logic [ASID_W-1:0]             i_asid,
    input  logic [ITLB_WAYS-1:0]          i_itlb_vld,
    input  logic [ITLB_WAYS*ASID_W-1:0]   i_itlb_asid,
    input  logic [ITLB_WAYS*VPN_W-1:0]    i_itlb_vpn,
    input  logic [ITLB_WAYS*PPN_W-1:0]    i_itlb_ppn,
    input  logic [ITLB_WAYS-1:0]          i_itlb_x,
    input  logic [ICACHE_WAYS-1:0]        i_ic_vld,
    input  logic [ICACHE_WAYS*PTAG_W-1:0] i_ic_ptag,
    input  logic [ICACHE_WAYS*LINE_W-1:0] i_ic_line,
    output logic                          o_valid,
    output logic [VA_W-1:0]               o_pc,
    output logic [FETCH_W-1:0]            o_data,
    output logic [FETCH_BYTES-1:0]        o_byte_mask,
    output logic                          o_except_valid,
    output logic [3:0]                    o_except_code,
    output logic                          o_miss_req_valid,
    input  logic                          i_miss_req_ready,
    output logic                          o_miss_req_type,
    output logic [PA_W-1:0]               o_miss_req_addr,
    input  logic                          i_miss_done,
    output logic                          o_redirect_valid,
    output logic [VA_W-1:0]               o_redirect_pc
);

    localparam int LINE_BITS = $clog2(LINE_BYTES);
    localparam int FB_BITS   = $clog2(FETCH_BYTES);
    localparam int NBLK      = LINE_BYTES / FETCH_BYTES;

    localparam logic [3:0] EXC_MISALIGN   = 4'd0;
    localparam logic [3:0] EXC_PAGE_FAULT = 4'd1;
    localparam logic [3:0] EXC_MCHECK     = 4'd2;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_REPLAY} state_e;

    state_e state_q, state_d;

    logic                   valid_q, valid_d;
    logic [VA_W-1:0]        pc_q, pc_d;
    logic [FETCH_W-1:0]     data_q, data_d;
    logic [FETCH_BYTES-1:0] mask_q, mask_d;
    logic                   exc_vld_q, exc_vld_d;
    logic [3:0]             exc_code_q, exc_code_d;

    logic                   cap_type_q, cap_type_d;
    logic [PA_W-1:0]        cap_addr_q, cap_addr_d;
    logic [VA_W-1:0]        cap_pc_q, cap_pc_d;

    logic [ITLB_WAYS-1:0]   tlb_hit;
    logic                   tlb_any, tlb_multi, tlb_x;
    logic [PPN_W-1:0]       tlb_ppn;
    logic [PA_W-1:0]        pa;
    logic [PTAG_W-1:0]      ptag;

    logic [ICACHE_WAYS-1:0] ic_hit;
    logic                   ic_any, ic_multi;
    logic [LINE_W-1:0]      ic_line;

    logic [FETCH_W-1:0]     blk_data;
    logic [FETCH_BYTES-1:0] bmask;

    logic                   cls_hit, cls_exc, cls_miss, miss_type;
    logic [3:0]             exc_code;
    logic [PA_W-1:0]        miss_addr;
    logic                   accept;

    // ITLB lookup; translated fields are OR-muxed, only meaningful on a single hit
    always_comb begin
        tlb_hit   = '0;
        tlb_any   = 1'b0;
        tlb_multi = 1'b0;
        tlb_x     = 1'b0;
        tlb_ppn   = '0;
        for (int w = 0; w < ITLB_WAYS; w++) begin
            tlb_hit[w] = i_itlb_vld[w]
                      && (i_itlb_asid[w*ASID_W +: ASID_W] == i_asid)
                      && (i_itlb_vpn[w*VPN_W +: VPN_W] == i_pc[VA_W-1:PAGE_BITS]);
            if (tlb_hit[w]) begin
                if (tlb_any) tlb_multi = 1'b1;
                tlb_any = 1'b1;
                tlb_x   = tlb_x | i_itlb_x[w];
                tlb_ppn = tlb_ppn | i_itlb_ppn[w*PPN_W +: PPN_W];
            end
        end
    end

    assign pa   = {tlb_ppn, i_pc[PAGE_BITS-1:0]};
    assign ptag = pa[PA_W-1 -: PTAG_W];

    always_comb begin
        ic_hit   = '0;
        ic_any   = 1'b0;
        ic_multi = 1'b0;
        ic_line  = '0;
        for (int w = 0; w < ICACHE_WAYS; w++) begin
            ic_hit[w] = tlb_any && !tlb_multi && i_ic_vld[w]
                     && (i_ic_ptag[w*PTAG_W +: PTAG_W] == ptag);
            if (ic_hit[w]) begin
                if (ic_any) ic_multi = 1'b1;
                ic_any  = 1'b1;
                ic_line = ic_line | i_ic_line[w*LINE_W +: LINE_W];
            end
        end
    end

    always_comb begin
        blk_data = '0;
        for (int k = 0; k < NBLK; k++) begin
            if (k == (int'(i_pc[LINE_BITS-1:0]) >> FB_BITS))
                blk_data = ic_line[k*FETCH_W +: FETCH_W];
        end
        for (int b = 0; b < FETCH_BYTES; b++)
            bmask[b] = (b >= int'(i_pc[FB_BITS-1:0]));
    end

    always_comb begin
        cls_hit   = 1'b0;
        cls_exc   = 1'b0;
        cls_miss  = 1'b0;
        miss_type = 1'b0;
        exc_code  = EXC_MISALIGN;
        if (i_pc[0]) begin
            cls_exc  = 1'b1;
            exc_code = EXC_MISALIGN;
        end else if (tlb_multi) begin
            cls_exc  = 1'b1;
            exc_code = EXC_MCHECK;
        end else if (!tlb_any) begin
            cls_miss  = 1'b1;
            miss_type = 1'b0;
        end else if (!tlb_x) begin
            cls_exc  = 1'b1;
            exc_code = EXC_PAGE_FAULT;
        end else if (ic_multi) begin
            cls_exc  = 1'b1;
            exc_code = EXC_MCHECK;
        end else if (!ic_any) begin
            cls_miss  = 1'b1;
            miss_type = 1'b1;
        end else begin
            cls_hit = 1'b1;
        end
    end

    assign miss_addr = miss_type ? {pa[PA_W-1:LINE_BITS], {LINE_BITS{1'b0}}}
                                 : PA_W'(i_pc);
    assign accept    = (state_q == S_IDLE) && i_valid && !i_stall && !i_flush;

    // Result registers: flush clears, stall holds, otherwise reload every cycle
    always_comb begin
        valid_d    = valid_q;
        pc_d       = pc_q;
        data_d     = data_q;
        mask_d     = mask_q;
        exc_vld_d  = exc_vld_q;
        exc_code_d = exc_code_q;
        if (i_flush || !i_stall) begin
            valid_d    = 1'b0;
            pc_d       = '0;
            data_d     = '0;
            mask_d     = '0;
            exc_vld_d  = 1'b0;
            exc_code_d = '0;
            if (accept && cls_hit) begin
                valid_d = 1'b1;
                pc_d    = i_pc;
                data_d  = blk_data;
                mask_d  = bmask;
            end else if (accept && cls_exc) begin
                valid_d    = 1'b1;
                pc_d       = i_pc;
                exc_vld_d  = 1'b1;
                exc_code_d = exc_code;
            end
        end
    end

    always_comb begin
        cap_pc_d   = cap_pc_q;
        cap_type_d = cap_type_q;
        cap_addr_d = cap_addr_q;
        if (accept && cls_miss) begin
            cap_pc_d   = i_pc;
            cap_type_d = miss_type;
            cap_addr_d = miss_addr;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= S_IDLE;
            valid_q    <= 1'b0;
            pc_q       <= '0;
            data_q     <= '0;
            mask_q     <= '0;
            exc_vld_q  <= 1'b0;
            exc_code_q <= '0;
            cap_pc_q   <= '0;
            cap_type_q <= 1'b0;
            cap_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            valid_q    <= valid_d;
            pc_q       <= pc_d;
            data_q     <= data_d;
            mask_q     <= mask_d;
            exc_vld_q  <= exc_vld_d;
            exc_code_q <= exc_code_d;
            cap_pc_q   <= cap_pc_d;
            cap_type_q <= cap_type_d;
            cap_addr_q <= cap_addr_d;
        end
    end

    // A handshake in a flush cycle is still consumed; the FSM simply abandons it
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (accept && cls_miss) state_d = S_REQ;
            S_REQ:    if (i_miss_req_ready)   state_d = S_WAIT;
            S_WAIT:   if (i_miss_done)        state_d = S_REPLAY;
            S_REPLAY: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
        if (i_flush) state_d = S_IDLE;
    end

    always_comb begin
        o_miss_req_valid = (state_q == S_REQ);
        o_redirect_valid = (state_q == S_REPLAY);
        o_redirect_pc    = (state_q == S_REPLAY) ? cap_pc_q : '0;
    end

    assign o_miss_req_type = cap_type_q;
    assign o_miss_req_addr = cap_addr_q;
    assign o_valid         = valid_q;
    assign o_pc            = pc_q;
    assign o_data          = data_q;
    assign o_byte_mask     = mask_q;
    assign o_except_valid  = exc_vld_q;
    assign o_except_code   = exc_code_q;

endmodule

// File: tb/tb_instr_fetch2_wide.sv
// Directed bench for instr_fetch2_wide: table of hit/exception vectors plus
// hand-written miss, flush, stall and reset sequences.
module tb_instr_fetch2_wide;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          stall, flush, valid;
    logic [31:0]   pc;
    logic [8:0]    asid;
    logic [3:0]    tlb_vld, tlb_x, ic_vld;
    logic [35:0]   tlb_asid;
    logic [79:0]   tlb_vpn;
    logic [87:0]   tlb_ppn;
    logic [87:0]   ic_ptag;
    logic [2047:0] ic_line;
    logic          o_valid, o_except_valid, o_mrv, o_mrt, o_rdv, ready, done;
    logic [31:0]   o_pc, o_rdpc;
    logic [63:0]   o_data;
    logic [7:0]    o_mask;
    logic [3:0]    o_code;
    logic [33:0]   o_mra;

    int errors = 0;
    int checks = 0;

    instr_fetch2_wide dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_stall(stall), .i_flush(flush),
        .i_valid(valid), .i_pc(pc), .i_asid(asid),
        .i_itlb_vld(tlb_vld), .i_itlb_asid(tlb_asid), .i_itlb_vpn(tlb_vpn),
        .i_itlb_ppn(tlb_ppn), .i_itlb_x(tlb_x),
        .i_ic_vld(ic_vld), .i_ic_ptag(ic_ptag), .i_ic_line(ic_line),
        .o_valid(o_valid), .o_pc(o_pc), .o_data(o_data), .o_byte_mask(o_mask),
        .o_except_valid(o_except_valid), .o_except_code(o_code),
        .o_miss_req_valid(o_mrv), .i_miss_req_ready(ready),
        .o_miss_req_type(o_mrt), .o_miss_req_addr(o_mra),
        .i_miss_done(done), .o_redirect_valid(o_rdv), .o_redirect_pc(o_rdpc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [8:0]  asid;
        logic        v;
        logic [3:0]  tv, tm, tx, iv, im;
        logic        e_valid, e_exc;
        logic [3:0]  e_code;
        logic [63:0] e_data;
        logic [7:0]  e_mask;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // tm/im select which ways carry the matching VPN / physical tag
    task automatic setup(input logic [3:0] tv, input logic [3:0] tm, input logic [3:0] tx,
                         input logic [3:0] iv, input logic [3:0] im,
                         input logic [31:0] p, input logic [8:0] a, input logic v);
        tlb_vld = tv;
        tlb_x   = tx;
        ic_vld  = iv;
        pc      = p;
        asid    = a;
        valid   = v;
        for (int w = 0; w < 4; w++) begin
            tlb_asid[w*9 +: 9]  = 9'd5;
            tlb_vpn[w*20 +: 20] = tm[w] ? 20'h12345 : (20'h0AAA0 + 20'(w));
            tlb_ppn[w*22 +: 22] = 22'h3ABCD;
            ic_ptag[w*22 +: 22] = im[w] ? 22'h3ABCD : 22'h11111;
        end
    endtask

    task automatic setup_hit(input logic [31:0] p);
        setup(4'b0100, 4'b0100, 4'b0100, 4'b0010, 4'b0010, p, 9'd5, 1'b1);
    endtask

    initial begin
        vecs[0] = '{32'h1234567A, 9'd5, 1'b1, 4'b0100, 4'b0100, 4'b0100, 4'b0010, 4'b0010,
                    1'b1, 1'b0, 4'd0, 64'h7F7E7D7C7B7A7978, 8'hFC};
        vecs[1] = '{32'h1234567B, 9'd5, 1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000,
                    1'b1, 1'b1, 4'd0, 64'h0, 8'h00};
        vecs[2] = '{32'h1234567B, 9'd5, 1'b1, 4'b0101, 4'b0101, 4'b0101, 4'b0010, 4'b0010,
                    1'b1, 1'b1, 4'd0, 64'h0, 8'h00};
        vecs[3] = '{32'h1234567A, 9'd5, 1'b1, 4'b0101, 4'b0101, 4'b0101, 4'b0010, 4'b0010,
                    1'b1, 1'b1, 4'd2, 64'h0, 8'h00};
        vecs[4] = '{32'h1234567A, 9'd5, 1'b1, 4'b0100, 4'b0100, 4'b0000, 4'b0010, 4'b0010,
                    1'b1, 1'b1, 4'd1, 64'h0, 8'h00};
        vecs[5] = '{32'h1234567A, 9'd5, 1'b1, 4'b0100, 4'b0100, 4'b0100, 4'b0011, 4'b0011,
                    1'b1, 1'b1, 4'd2, 64'h0, 8'h00};
        vecs[6] = '{32'h12345000, 9'd5, 1'b1, 4'b0100, 4'b0100, 4'b0100, 4'b0010, 4'b0010,
                    1'b1, 1'b0, 4'd0, 64'h4746454443424140, 8'hFF};
        vecs[7] = '{32'h12345006, 9'd5, 1'b1, 4'b0100, 4'b0100, 4'b0100, 4'b1000, 4'b1000,
                    1'b1, 1'b0, 4'd0, 64'hC7C6C5C4C3C2C1C0, 8'hC0};
        vecs[8] = '{32'h1234567A, 9'd5, 1'b0, 4'b0100, 4'b0100, 4'b0100, 4'b0010, 4'b0010,
                    1'b0, 1'b0, 4'd0, 64'h0, 8'h00};

        for (int w = 0; w < 4; w++)
            for (int i = 0; i < 64; i++)
                ic_line[w*512 + i*8 +: 8] = 8'(w*64 + i);

        rst_n = 1'b0;
        stall = 1'b0; flush = 1'b0; ready = 1'b0; done = 1'b0;
        setup(4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 32'h0, 9'd0, 1'b0);
        #12;
        check("rst_valid", o_valid, 0);
        check("rst_pc", o_pc, 0);
        check("rst_data", o_data, 0);
        check("rst_except", {o_except_valid, o_code}, 0);
        check("rst_miss_req", {o_mrv, o_mrt, o_mra}, 0);
        check("rst_redirect", {o_rdv, o_rdpc}, 0);
        rst_n = 1'b1;

        for (int i = 0; i < 9; i++) begin
            setup(vecs[i].tv, vecs[i].tm, vecs[i].tx, vecs[i].iv, vecs[i].im,
                  vecs[i].pc, vecs[i].asid, vecs[i].v);
            step();
            check($sformatf("v%0d_valid", i), o_valid, vecs[i].e_valid);
            check($sformatf("v%0d_pc", i), o_pc, vecs[i].e_valid ? vecs[i].pc : 32'h0);
            check($sformatf("v%0d_except", i), {o_except_valid, o_code}, {vecs[i].e_exc, vecs[i].e_code});
            check($sformatf("v%0d_data", i), o_data, vecs[i].e_data);
            check($sformatf("v%0d_mask", i), o_mask, vecs[i].e_mask);
            check($sformatf("v%0d_no_miss", i), o_mrv, 0);
        end

        // ITLB miss, ready held low, then refill and replay
        setup(4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 32'h1234567A, 9'd5, 1'b1);
        step();
        check("tlbmiss_valid", o_valid, 0);
        check("tlbmiss_req", {o_mrv, o_mrt, o_mra}, {1'b1, 1'b0, 34'h01234567A});
        setup_hit(32'h1234567A);
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("tlbmiss_hold%0d", i), {o_mrv, o_mrt, o_mra}, {1'b1, 1'b0, 34'h01234567A});
            check($sformatf("tlbmiss_ignore%0d", i), o_valid, 0);
        end
        ready = 1'b1;
        step();
        ready = 1'b0;
        valid = 1'b0;
        check("tlbmiss_req_drop", o_mrv, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("tlbmiss_wait%0d", i), o_rdv, 0);
        end
        done = 1'b1;
        step();
        done = 1'b0;
        check("tlbmiss_redirect", {o_rdv, o_rdpc}, {1'b1, 32'h1234567A});
        step();
        check("tlbmiss_redirect_end", {o_rdv, o_rdpc}, 0);

        // I-cache miss, flush while waiting, late completion ignored
        setup(4'b0100, 4'b0100, 4'b0100, 4'b1111, 4'b0000, 32'h1234567A, 9'd5, 1'b1);
        step();
        check("icmiss_req", {o_mrv, o_mrt, o_mra}, {1'b1, 1'b1, 34'h3ABCD640});
        check("icmiss_valid", o_valid, 0);
        valid = 1'b0;
        ready = 1'b1;
        step();
        ready = 1'b0;
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("icflush_redirect", o_rdv, 0);
        done = 1'b1;
        step();
        done = 1'b0;
        check("icflush_done_ignored", o_rdv, 0);
        step();
        check("icflush_done_ignored2", o_rdv, 0);
        setup_hit(32'h1234567A);
        step();
        check("icflush_idle_hit", o_valid, 1);
        check("icflush_idle_noreq", o_mrv, 0);

        // Flush coinciding with an accepted handshake
        setup(4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 32'h1234567A, 9'd6, 1'b1);
        step();
        check("asid_miss_req", {o_mrv, o_mrt}, 2'b10);
        valid = 1'b0;
        flush = 1'b1;
        ready = 1'b1;
        step();
        flush = 1'b0;
        ready = 1'b0;
        check("flush_hs_req", o_mrv, 0);
        done = 1'b1;
        step();
        done = 1'b0;
        check("flush_hs_done_ignored", o_rdv, 0);
        step();
        check("flush_hs_no_redirect", o_rdv, 0);

        // Stall holds a hit result; flush overrides stall
        setup_hit(32'h1234567A);
        step();
        check("stall_pre", o_valid, 1);
        stall = 1'b1;
        setup(4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 32'h1234567B, 9'd5, 1'b1);
        for (int i = 0; i < 2; i++) begin
            step();
            check($sformatf("stall_hold%0d", i),
                  {o_valid, o_except_valid, o_mask}, {1'b1, 1'b0, 8'hFC});
            check($sformatf("stall_data%0d", i), o_data, 64'h7F7E7D7C7B7A7978);
            check($sformatf("stall_pc%0d", i), o_pc, 32'h1234567A);
            check($sformatf("stall_noreq%0d", i), o_mrv, 0);
        end
        flush = 1'b1;
        step();
        flush = 1'b0;
        stall = 1'b0;
        check("stall_flush_valid", o_valid, 0);
        check("stall_flush_data", o_data, 0);

        // Asynchronous reset while a refill request is outstanding
        setup(4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 32'h1234567A, 9'd5, 1'b1);
        step();
        check("rstreq_pre", o_mrv, 1);
        valid = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        check("rstreq_req_drop", {o_mrv, o_mrt, o_mra}, 0);
        check("rstreq_outputs", {o_valid, o_except_valid, o_rdv, o_pc}, 0);
        #3;
        rst_n = 1'b1;
        step();
        check("rstreq_idle", o_mrv, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
